mult_q_arb: RTL

Round-robin arbiter and pipeline controller that shares one Q5.27 fixed-point multiplier (`mult_Q`, WIDTH=32, FBITS=27) among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants at most one request per cycle, registers the operands, and drives the shared combinational multiplier. It returns the registered product tagged with the requester ID through a single valid/ready result port. It sits between the layer compute units and the single multiplier instance to save area.

---
 rtl/mult_q_arb.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mult_q_arb.sv
// Round-robin arbiter sharing one Q5.27 multiplier across NREQ requesters.
// Optional per-requester grant counters are built when MQ_ARB_PERF_EN is defined.
module mult_Q #(
    parameter int WIDTH = 32,
    parameter int FBITS = 27
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);
    logic signed [2*WIDTH-1:0] w_prod;

    assign w_prod = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a})
                  * $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
    // Arithmetic shift floors toward -inf; the low WIDTH bits wrap.
    assign o_y = WIDTH'(w_prod >>> FBITS);
endmodule

module mult_q_arb #(
    parameter int WIDTH = 32,
    parameter int FBITS = 27,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic [IDW-1:0]        res_id
`ifdef MQ_ARB_PERF_EN
    ,
    output logic [NREQ*16-1:0]    grant_cnt
`endif
);
    logic [IDW-1:0]   r_ptr;
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_a1;
    logic [WIDTH-1:0] r_b1;
    logic [IDW-1:0]   r_id1;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;
    logic [IDW-1:0]   r_s2_id;

    logic             w_s2_load;
    logic             w_s1_load;
    logic             w_any;
    logic             w_grant;
    logic [NREQ-1:0]  w_rot;
    logic [IDW-1:0]   w_gnt_id;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [WIDTH-1:0] w_a_sel;
    logic [WIDTH-1:0] w_b_sel;
    logic [WIDTH-1:0] w_y;

    assign w_s2_load = !r_s2_valid || res_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;

    // Rotate so bit 0 is the requester at ptr; lowest set bit wins.
    assign w_rot = NREQ'({req_valid, req_valid} >> r_ptr);

    always_comb begin
        int s;
        int t;
        s         = 0;
        t         = 0;
        w_any     = 1'b0;
        w_gnt_id  = '0;
        w_ptr_nxt = r_ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_any = 1'b1;
                s     = int'(r_ptr) + i;
                if (s >= NREQ) s = s - NREQ;
                w_gnt_id = IDW'(s);
            end
        end
        t = int'(w_gnt_id) + 1;
        if (t >= NREQ) t = 0;
        w_ptr_nxt = IDW'(t);
    end

    assign w_grant   = rst_n && w_any && w_s1_load;
    assign req_ready = w_grant ? (NREQ'(1) << w_gnt_id) : '0;
    assign w_a_sel   = req_a[w_gnt_id*WIDTH +: WIDTH];
    assign w_b_sel   = req_b[w_gnt_id*WIDTH +: WIDTH];

    mult_Q #(
        .WIDTH (WIDTH),
        .FBITS (FBITS)
    ) u_mult (
        .i_a (r_a1),
        .i_b (r_b1),
        .o_y (w_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_s1_valid <= 1'b0;
            r_a1       <= '0;
            r_b1       <= '0;
            r_id1      <= '0;
        end else begin
            if (w_s1_load) r_s1_valid <= w_grant;
            if (w_grant) begin
                r_a1  <= w_a_sel;
                r_b1  <= w_b_sel;
                r_id1 <= w_gnt_id;
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_id    <= '0;
        end else begin
            if (w_s2_load) r_s2_valid <= r_s1_valid;
            if (w_s2_load && r_s1_valid) begin
                r_s2_data <= w_y;
                r_s2_id   <= r_id1;
            end
        end
    end

    assign res_valid = r_s2_valid;
    assign res_data  = r_s2_data;
    assign res_id    = r_s2_id;

`ifdef MQ_ARB_PERF_EN
    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        logic [15:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (req_valid[g] && req_ready[g] && r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
        assign grant_cnt[g*16 +: 16] = r_cnt;
    end
`endif
endmodule
